// File: rtl/fifo_sync_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_sync_pkg
// Brief    : Gray/binary helpers and shared constants for async FIFO pointers.
// Revision : 1.0
// ============================================================================
package fifo_sync_pkg;

    localparam int c_default_num_address = 8;
    localparam int c_max_ptr_w           = 32;

    typedef logic [c_max_ptr_w-1:0] ptr_word_t;

    typedef struct packed {
        logic full;
        logic almost_full;
    } fifo_flags_t;

    function automatic ptr_word_t bin2gray(input ptr_word_t b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic ptr_word_t gray2bin(input ptr_word_t g);
        ptr_word_t b;
        b = g;
        for (int i = 1; i < c_max_ptr_w; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_write_pointer_full_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_write_pointer_full_if
// Brief    : Write-side FIFO control bundle between producer and pointer logic.
// Revision : 1.0
// ============================================================================
interface fifo_write_pointer_full_if
    import fifo_sync_pkg::*;
#(
    parameter int NUM_ADDRESS = c_default_num_address
);
    localparam int ADDR_W = $clog2(NUM_ADDRESS);
    localparam int PTR_W  = ADDR_W + 1;

    logic              write_enable;
    logic [PTR_W-1:0]  read_pointer_sync;
    logic              write_strobe;
    logic [PTR_W-1:0]  write_pointer;
    logic [ADDR_W-1:0] write_address;
    logic              fifo_full;
    logic              almost_full;
    logic [PTR_W-1:0]  write_count;
    logic              overflow_error;

    modport master (
        output write_enable, read_pointer_sync,
        input  write_strobe, write_pointer, write_address, fifo_full,
               almost_full, write_count, overflow_error
    );

    modport slave (
        input  write_enable, read_pointer_sync,
        output write_strobe, write_pointer, write_address, fifo_full,
               almost_full, write_count, overflow_error
    );
endinterface
`default_nettype wire

// File: rtl/fifo_gray_counter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_gray_counter
// Brief    : Binary pointer with registered Gray copy; shared by both FIFO sides.
// Revision : 1.0
// ============================================================================
module fifo_gray_counter
    import fifo_sync_pkg::*;
#(
    parameter int PTR_W = 4
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             inc,
    output logic      [PTR_W-1:0] binary,
    output logic      [PTR_W-1:0] gray,
    output logic      [PTR_W-1:0] binary_next
);
    logic [PTR_W-1:0] r_bin;
    logic [PTR_W-1:0] r_gray;

    assign binary_next = r_bin + PTR_W'(inc);

    // Gray register is loaded from binary_next so it never lags the binary copy.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_bin  <= '0;
            r_gray <= '0;
        end else begin
            r_bin  <= binary_next;
            r_gray <= PTR_W'(bin2gray(ptr_word_t'(binary_next)));
        end
    end

    assign binary = r_bin;
    assign gray   = r_gray;
endmodule
`default_nettype wire

// File: rtl/fifo_write_pointer_full.sv
`default_nettype none
// ============================================================================
// Module   : fifo_write_pointer_full
// Brief    : Async FIFO write pointer, full/almost-full flags and occupancy.
//            Define FIFO_WRITE_OVERFLOW_EN to enable sticky overflow detection.
// Revision : 1.0
// ============================================================================
module fifo_write_pointer_full
    import fifo_sync_pkg::*;
#(
    parameter int NUM_ADDRESS       = c_default_num_address,
    parameter int ALMOST_FULL_LEVEL = NUM_ADDRESS - 2
) (
    input wire logic                 write_clk,
    input wire logic                 write_reset,
    fifo_write_pointer_full_if.slave bus
);
    localparam int ADDR_W = $clog2(NUM_ADDRESS);
    localparam int PTR_W  = ADDR_W + 1;
    localparam logic [PTR_W-1:0] c_af_level = PTR_W'(ALMOST_FULL_LEVEL);

    logic             w_accept;
    logic [PTR_W-1:0] w_wbin;
    logic [PTR_W-1:0] w_wgray;
    logic [PTR_W-1:0] w_wbin_next;
    logic [PTR_W-1:0] w_rbin;
    logic [PTR_W-1:0] w_full_target;
    logic [PTR_W-1:0] w_count_next;
    logic             w_full_next;
    logic             w_af_next;

    fifo_flags_t      r_flags;
    logic [PTR_W-1:0] r_count;

    // Reset blocks the RAM strobe so a write during reset never lands in memory.
    assign w_accept = write_reset & bus.write_enable & ~r_flags.full;

    fifo_gray_counter #(
        .PTR_W (PTR_W)
    ) u_wptr (
        .clk         (write_clk),
        .reset       (write_reset),
        .inc         (w_accept),
        .binary      (w_wbin),
        .gray        (w_wgray),
        .binary_next (w_wbin_next)
    );

    assign w_rbin        = PTR_W'(gray2bin(ptr_word_t'(bus.read_pointer_sync)));
    // Full when the next write pointer laps the read pointer: top two Gray bits inverted.
    assign w_full_target = {~bus.read_pointer_sync[PTR_W-1:PTR_W-2],
                             bus.read_pointer_sync[PTR_W-3:0]};
    assign w_full_next   = (PTR_W'(bin2gray(ptr_word_t'(w_wbin_next))) == w_full_target);
    assign w_count_next  = w_wbin_next - w_rbin;
    assign w_af_next     = (w_count_next >= c_af_level);

    always_ff @(posedge write_clk) begin
        if (!write_reset) begin
            r_flags <= '0;
            r_count <= '0;
        end else begin
            r_flags.full        <= w_full_next;
            r_flags.almost_full <= w_af_next;
            r_count             <= w_count_next;
        end
    end

`ifdef FIFO_WRITE_OVERFLOW_EN
    logic r_overflow;

    always_ff @(posedge write_clk) begin
        if (!write_reset) begin
            r_overflow <= 1'b0;
        end else if (bus.write_enable && r_flags.full) begin
            r_overflow <= 1'b1;
        end
    end

    assign bus.overflow_error = r_overflow;
`else
    assign bus.overflow_error = 1'b0;
`endif

    assign bus.write_strobe  = w_accept;
    assign bus.write_pointer = w_wgray;
    assign bus.write_address = w_wbin[ADDR_W-1:0];
    assign bus.fifo_full     = r_flags.full;
    assign bus.almost_full   = r_flags.almost_full;
    assign bus.write_count   = r_count;
endmodule
`default_nettype wire

// File: tb/tb_fifo_write_pointer_full.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_write_pointer_full
// Brief    : Vector-table bench for the FIFO write pointer (depth 8, AF level 6).
// Revision : 1.0
// ============================================================================
module tb_fifo_write_pointer_full;

    typedef struct {
        logic       rst_n;
        logic       we;
        logic [3:0] rps;
        logic       exp_strobe;
        logic [3:0] exp_wptr;
        logic [2:0] exp_addr;
        logic       exp_full;
        logic       exp_af;
        logic [3:0] exp_count;
        logic       exp_ovf;
    } vec_t;

`ifdef FIFO_WRITE_OVERFLOW_EN
    localparam logic c_ovf_en = 1'b1;
`else
    localparam logic c_ovf_en = 1'b0;
`endif

    logic write_clk;
    logic write_reset;

    fifo_write_pointer_full_if #(.NUM_ADDRESS(8)) bus ();

    fifo_write_pointer_full #(
        .NUM_ADDRESS       (8),
        .ALMOST_FULL_LEVEL (6)
    ) dut (
        .write_clk   (write_clk),
        .write_reset (write_reset),
        .bus         (bus.slave)
    );

    initial write_clk = 1'b0;
    always #5 write_clk = ~write_clk;

    logic [3:0] gray_tab [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                                  4'b0110, 4'b0111, 4'b0101, 4'b0100,
                                  4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                  4'b1010, 4'b1011, 4'b1001, 4'b1000};

    int   n_pass  = 0;
    int   n_total = 0;
    vec_t sb_q[$];
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Drive one cycle, check the combinational strobe, then check registered outputs.
    task automatic apply(input vec_t v);
        vec_t e;
        write_reset           = v.rst_n;
        bus.write_enable      = v.we;
        bus.read_pointer_sync = v.rps;
        #1;
        chk("write_strobe", 32'(bus.write_strobe), 32'(v.exp_strobe));
        sb_q.push_back(v);
        @(posedge write_clk);
        #1;
        e = sb_q.pop_front();
        chk("write_pointer",  32'(bus.write_pointer),  32'(e.exp_wptr));
        chk("write_address",  32'(bus.write_address),  32'(e.exp_addr));
        chk("fifo_full",      32'(bus.fifo_full),      32'(e.exp_full));
        chk("almost_full",    32'(bus.almost_full),    32'(e.exp_af));
        chk("write_count",    32'(bus.write_count),    32'(e.exp_count));
        chk("overflow_error", 32'(bus.overflow_error), 32'(e.exp_ovf));
    endtask

    initial begin
        write_reset           = 1'b0;
        bus.write_enable      = 1'b0;
        bus.read_pointer_sync = 4'b0000;

        // Reset held while writing, then fill, overrun, release, refill, mid-fill reset.
        vecs.push_back('{1'b0, 1'b1, 4'b0000, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b0, 4'd0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 4'b0000, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b0, 4'd0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 4'b0000, 1'b1, 4'b0001, 3'd1, 1'b0, 1'b0, 4'd1, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 4'b0000, 1'b1, 4'b0011, 3'd2, 1'b0, 1'b0, 4'd2, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 4'b0000, 1'b1, 4'b0010, 3'd3, 1'b0, 1'b0, 4'd3, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 4'b0000, 1'b1, 4'b0110, 3'd4, 1'b0, 1'b0, 4'd4, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 4'b0000, 1'b1, 4'b0111, 3'd5, 1'b0, 1'b0, 4'd5, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 4'b0000, 1'b1, 4'b0101, 3'd6, 1'b0, 1'b1, 4'd6, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 4'b0000, 1'b1, 4'b0100, 3'd7, 1'b0, 1'b1, 4'd7, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 4'b0000, 1'b1, 4'b1100, 3'd0, 1'b1, 1'b1, 4'd8, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 4'b0000, 1'b0, 4'b1100, 3'd0, 1'b1, 1'b1, 4'd8, c_ovf_en});
        vecs.push_back('{1'b1, 1'b0, 4'b0001, 1'b0, 4'b1100, 3'd0, 1'b0, 1'b1, 4'd7, c_ovf_en});
        vecs.push_back('{1'b1, 1'b1, 4'b0001, 1'b1, 4'b1101, 3'd1, 1'b1, 1'b1, 4'd8, c_ovf_en});
        vecs.push_back('{1'b0, 1'b1, 4'b0001, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b0, 4'd0, 1'b0});

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
        end

        // Wrap: read side catches up every cycle, so occupancy stays at one.
        for (int i = 0; i < 20; i++) begin
            apply('{1'b1, 1'b1, gray_tab[i % 16], 1'b1, gray_tab[(i + 1) % 16],
                    3'((i + 1) % 8), 1'b0, 1'b0, 4'd1, 1'b0});
        end

        // Simultaneous write and read advance at an occupancy of five.
        apply('{1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b0, 4'd0, 1'b0});
        for (int i = 1; i <= 5; i++) begin
            apply('{1'b1, 1'b1, 4'b0000, 1'b1, gray_tab[i], 3'(i), 1'b0, 1'b0, 4'(i), 1'b0});
        end
        apply('{1'b1, 1'b1, 4'b0001, 1'b1, 4'b0101, 3'd6, 1'b0, 1'b0, 4'd5, 1'b0});
        apply('{1'b1, 1'b0, 4'b0011, 1'b0, 4'b0101, 3'd6, 1'b0, 1'b0, 4'd4, 1'b0});

        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_write_pointer_full.md
FIFO_WRITE_POINTER_FULL -- requirements
Module: fifo_write_pointer_full

Interface
REQ-001 SHALL have parameter NUM_ADDRESS, default 8, FIFO depth in words; power of two, >= 4.
REQ-002 SHALL have parameter ALMOST_FULL_LEVEL, default NUM_ADDRESS-2, word count at which almost_full asserts; range 1..NUM_ADDRESS.
REQ-003 SHALL define ADDR_W = $clog2(NUM_ADDRESS) and PTR_W = ADDR_W+1.
REQ-004 SHALL have write_clk  input  1  write-domain clock; one clock, all logic on its rising edge.
REQ-005 SHALL have write_reset  input  1  reset; synchronous, active-low.
REQ-006 SHALL have write_enable  input  1  write request from producer.
REQ-007 SHALL have read_pointer_sync  input  PTR_W  read pointer, Gray code, already synchronized into write_clk.
REQ-008 SHALL have write_pointer  output  PTR_W  write pointer, Gray code, registered.
REQ-009 SHALL have write_address  output  ADDR_W  RAM write address, binary = low ADDR_W bits of binary write pointer.
REQ-010 SHALL have fifo_full  output  1  registered full flag.
REQ-011 SHALL have almost_full  output  1  registered threshold flag.
REQ-012 SHALL have write_count  output  PTR_W  registered occupancy seen from write side, 0..NUM_ADDRESS.
REQ-013 SHALL have overflow_error  output  1  sticky write-while-full flag.

Function
REQ-014 Write accepted (accept) iff write_enable=1 and fifo_full=0 at the clock edge; RAM write strobe equals accept, using current write_address.
REQ-015 Binary pointer wbin SHALL be held in a register; wbin_next = wbin + accept, modulo 2^PTR_W (natural wrap, no saturation).
REQ-016 write_pointer SHALL equal bin2gray(wbin) registered alongside wbin; exactly one bit changes per accepted write.
REQ-017 full_next = (bin2gray(wbin_next) == {~read_pointer_sync[PTR_W-1:PTR_W-2], read_pointer_sync[PTR_W-3:0]}); fifo_full <= full_next each cycle.
REQ-018 rbin = gray2bin(read_pointer_sync); write_count <= wbin_next - rbin, PTR_W-bit modulo subtraction.
REQ-019 almost_full <= (wbin_next - rbin) >= ALMOST_FULL_LEVEL.
REQ-020 Latency: pointer, address, count and flags reflect an accepted write on the edge that accepts it; read_pointer_sync changes are reflected one edge later.
REQ-021 fifo_full deassertion is pessimistic: releases only after read_pointer_sync shows freed space; block SHALL never allow count > NUM_ADDRESS.
REQ-022 write_enable while fifo_full=1: no pointer change, no RAM write, flags unchanged except per REQ-026.
REQ-023 Simultaneous accepted write and read_pointer_sync advance: both applied in the same next-state computation; count unchanged.

Reset
REQ-024 While write_reset=0 at an edge: wbin=0, write_pointer=0, write_address=0, fifo_full=0, almost_full=0, write_count=0, overflow_error=0; reset overrides write_enable, including mid-fill.

Configuration
REQ-025 Macro FIFO_WRITE_OVERFLOW_EN selects overflow detection.
REQ-026 Defined: overflow_error <= 1 on any edge with write_enable=1 and fifo_full=1; held until reset.
REQ-027 Undefined: port remains, driven constant 0; no detection logic.

Structure
REQ-028 Package fifo_sync_pkg SHALL hold bin2gray/gray2bin functions and default depth constant, shared with the read-side block.
REQ-029 One sub-module fifo_gray_counter (parameter PTR_W; clk, reset, inc -> binary, gray, binary_next) SHALL implement REQ-015/016 and be reusable on the read side.

Verification (NUM_ADDRESS=8, ALMOST_FULL_LEVEL=6)
REQ-030 Reset: hold write_reset=0 during write_enable=1 -> all outputs 0 after edge.
REQ-031 Fill: read_pointer_sync=0000, write_enable=1 for 8 edges -> write_address 0..7, after 6th almost_full=1, after 8th fifo_full=1, write_pointer=1100, write_count=8.
REQ-032 Overrun: 9th write while full -> write_pointer stays 1100, no strobe; overflow_error=1 with macro, 0 without.
REQ-033 Release: from full, read_pointer_sync=0001 -> next edge fifo_full=0, write_count=7.
REQ-034 Wrap: 20 writes with read side tracking -> write_pointer=0110 (binary 4), write_address=4, fifo_full never set.
REQ-035 Simultaneous: count=5, accepted write and read_pointer_sync advance by one same cycle -> write_count stays 5.
